fifo_w_drain: RTL and testbench
===============================

FIFO_W_DRAIN -- requirements
Module: fifo_w_drain

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: width of FIFO and output data.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 4: width of burst length field (beats-1).
REQ-003 The block SHALL have port clk, input, 1: single clock; all logic on positive edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port cmd_valid, input, 1: burst command offered.
REQ-006 The block SHALL have port cmd_len, input, LEN_WIDTH: burst beats minus 1.
REQ-007 The block SHALL have port cmd_ready, output, 1: command accepted when cmd_valid&&cmd_ready.
REQ-008 The block SHALL have port fifo_nempty, input, 1: upstream register FIFO holds data; fifo_data is valid (first-word fall-through).
REQ-009 The block SHALL have port fifo_data, input, DATA_WIDTH: upstream FIFO head word.
REQ-010 The block SHALL have port fifo_re, output, 1: pop upstream FIFO head this cycle.
REQ-011 The block SHALL have port wdata, output, DATA_WIDTH: AXI-W style data.
REQ-012 The block SHALL have port wvalid, output, 1: wdata valid.
REQ-013 The block SHALL have port wlast, output, 1: final beat of burst.
REQ-014 The block SHALL have port wready, input, 1: downstream accepts beat when wvalid&&wready.
REQ-015 The block SHALL have port busy, output, 1: burst in progress.
REQ-016 The block SHALL have port burst_done, output, 1: one-cycle pulse after final beat handshake.

Function
REQ-017 The block SHALL implement two states: IDLE and BURST.
REQ-018 In IDLE, cmd_ready SHALL be 1; in BURST, cmd_ready SHALL be 0.
REQ-019 On cmd_valid&&cmd_ready, the block SHALL load fetch_left <= cmd_len+1 (LEN_WIDTH+1 bits, no overflow) and enter BURST next cycle.
REQ-020 busy SHALL equal (state==BURST).
REQ-021 fifo_re SHALL be 1 exactly when state==BURST && fifo_nempty && fetch_left!=0 && (!wvalid || wready); combinational, no registered delay.
REQ-022 fifo_re SHALL never assert in IDLE, when fifo_nempty=0, or when fetch_left=0.
REQ-023 On fifo_re, the block SHALL decrement fetch_left and, next cycle, present wdata=fifo_data, wvalid=1, wlast=(fetch_left==1 before decrement).
REQ-024 On wvalid&&wready without fifo_re, wvalid SHALL clear next cycle; wvalid&&wready with fifo_re SHALL reload the output register back-to-back (1 beat/clk sustained).
REQ-025 While wvalid&&!wready, wdata and wlast SHALL hold stable and wvalid SHALL stay 1.
REQ-026 On handshake with wlast=1, state SHALL return to IDLE next cycle and burst_done SHALL pulse 1 for exactly that cycle.
REQ-027 A new command SHALL be accepted no earlier than the cycle after the final handshake (one-cycle bubble between bursts is required behaviour).
REQ-028 cmd_len=0 SHALL produce a single beat with wlast=1.
REQ-029 An empty FIFO mid-burst SHALL stall fetching with no beat dropped, duplicated or reordered; wvalid drops after the pending beat handshakes.
REQ-030 Beats SHALL leave in FIFO pop order; count per burst SHALL equal cmd_len+1 exactly.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, fetch_left=0, wvalid=0, wlast=0, burst_done=0, busy=0; wdata SHALL be 0.
REQ-032 While rst=1, fifo_re SHALL be 0 and cmd_ready SHALL be 0.
REQ-033 Reset mid-burst SHALL abort the burst; already-popped words are discarded, none re-emitted.

Verification
REQ-034 The bench SHALL cover this case: cmd_len=3, FIFO holds A,B,C,D, wready=1 -> fifo_re 4 consecutive cycles; wdata A..D on 4 consecutive cycles; wlast only with D; burst_done 1 cycle after D.
REQ-035 The bench SHALL cover this case: cmd_len=0, one word X -> single beat X with wlast=1; busy high 2 cycles.
REQ-036 The bench SHALL cover this case: cmd_len=7, wready toggling 1/0 each cycle -> wdata stable during stalls; 8 beats in order; no fifo_re while wvalid&&!wready.
REQ-037 The bench SHALL cover this case: cmd_len=3 with FIFO empty after 2 words, refilled 5 cycles later -> beats 1,2 then gap, then 3,4 with wlast on 4.
REQ-038 The bench SHALL cover this case: rst asserted after 2 of 4 beats -> next cycle wvalid=0, busy=0, cmd_ready=0 during rst, =1 after; next burst starts clean.
REQ-039 The bench SHALL cover this case: cmd_valid held high through two bursts of len 1 -> second accepted exactly 1 cycle after first final handshake; total 4 beats in order.

Source files
------------

// File: rtl/fifo_w_drain.sv
// fifo_w_drain: drains bursts of words from an upstream first-word-fall-through
// FIFO onto an AXI-W style valid/ready stream. Each accepted command moves
// exactly cmd_len+1 words, marking the final one with wlast.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   cmd_valid/cmd_len/cmd_ready  burst command (len = beats-1)
//   fifo_nempty/fifo_data/fifo_re  upstream FWFT FIFO head and pop strobe
//   wdata/wvalid/wlast/wready    downstream beat stream
//   busy                      burst in progress
//   burst_done                one-cycle pulse after the final beat handshake
module fifo_w_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  input  logic                  fifo_nempty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  output logic                  wlast,
  input  logic                  wready,
  output logic                  busy,
  output logic                  burst_done
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [LEN_WIDTH:0] ONE = (LEN_WIDTH+1)'(1);

  state_e                state_q, state_d;
  // Words still to be popped for the current burst; one extra bit so that
  // cmd_len all-ones + 1 fits.
  logic [LEN_WIDTH:0]    fetch_left_q, fetch_left_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wvalid_q, wvalid_d;
  logic                  wlast_q, wlast_d;
  logic                  done_q, done_d;
  logic                  cmd_acc, w_hs;

  always_comb begin
    state_d      = state_q;
    fetch_left_d = fetch_left_q;
    wdata_d      = wdata_q;
    wvalid_d     = wvalid_q;
    wlast_d      = wlast_q;
    done_d       = 1'b0;

    cmd_ready = (state_q == IDLE) && !rst;
    cmd_acc   = cmd_valid && cmd_ready;
    w_hs      = wvalid_q && wready;
    // Pop only when the output register is free or being emptied this cycle,
    // which gives one beat per clock while wready stays high.
    fifo_re   = !rst && (state_q == BURST) && fifo_nempty &&
                (fetch_left_q != '0) && (!wvalid_q || wready);

    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          fetch_left_d = {1'b0, cmd_len} + ONE;
          state_d      = BURST;
        end
      end
      BURST: begin
        if (w_hs && wlast_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_re) begin
      fetch_left_d = fetch_left_q - ONE;
      wdata_d      = fifo_data;
      wvalid_d     = 1'b1;
      wlast_d      = (fetch_left_q == ONE);
    end else if (w_hs) begin
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_left_q <= '0;
      wdata_q      <= '0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_left_q <= fetch_left_d;
      wdata_q      <= wdata_d;
      wvalid_q     <= wvalid_d;
      wlast_q      <= wlast_d;
      done_q       <= done_d;
    end
  end

  assign wdata      = wdata_q;
  assign wvalid     = wvalid_q;
  assign wlast      = wlast_q;
  assign busy       = (state_q == BURST);
  assign burst_done = done_q;

endmodule

// File: tb/tb_fifo_w_drain.sv
// Bench for fifo_w_drain. The upstream FIFO is a queue; the reference keeps
// the stream of pushed words and the per-burst beat count, and predicts the
// handshake-level behaviour cycle by cycle.
module tb_fifo_w_drain;
  localparam int DW = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, fifo_nempty, fifo_re;
  logic          wvalid, wlast, wready, busy, burst_done;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] fifo_data, wdata;

  always #5 clk = ~clk;

  fifo_w_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .fifo_nempty(fifo_nempty), .fifo_data(fifo_data),
    .fifo_re(fifo_re), .wdata(wdata), .wvalid(wvalid), .wlast(wlast),
    .wready(wready), .busy(busy), .burst_done(burst_done)
  );

  int npass = 0, ntot = 0;
  logic [DW-1:0] src[$];        // upstream FIFO contents
  logic [DW-1:0] ref_words[$];  // words not yet emitted, in push order
  int cyc = 0, busy_cnt = 0;
  int hs_cyc[$], re_cyc[$], acc_cyc[$], done_cyc[$];

  // reference state
  bit m_busy = 0, m_done = 0, m_stall = 0, m_hold_last = 0;
  int m_fetch = 0, m_len = 0, m_beat = 0, m_inflight = 0;
  logic [DW-1:0] m_hold_data = '0;
  int cmds_pending = 0, push_owed = 0, wr_mode = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive();
    fifo_nempty = (src.size() != 0);
    fifo_data   = (src.size() != 0) ? src[0] : 16'hDEAD;
  endtask

  task automatic push(logic [DW-1:0] w);
    src.push_back(w);
    ref_words.push_back(w);
    drive();
  endtask

  task automatic send_cmd(int len, int n);
    cmd_len      = LW'(len);
    cmd_valid    = 1'b1;
    cmds_pending = n;
  endtask

  task automatic clear_logs();
    hs_cyc.delete(); re_cyc.delete(); acc_cyc.delete(); done_cyc.delete();
    busy_cnt = 0;
  endtask

  // One clock: check at the falling edge, advance the reference past the
  // rising edge, then update the upstream FIFO and random stimulus.
  task automatic tick();
    bit hs, er, acc, pop, last_hs, wv, stall_next;
    @(negedge clk);
    cyc++;
    wv = (m_inflight != 0);
    er = !rst && m_busy && (src.size() != 0) && (m_fetch != 0) && (!wv || wready);
    chk("cmd_ready", cmd_ready, !rst && !m_busy);
    chk("fifo_re", fifo_re, er);
    chk("wvalid", wvalid, wv);
    chk("busy", busy, m_busy);
    chk("burst_done", burst_done, m_done);
    if (m_stall) begin
      chk("hold_wdata", wdata, m_hold_data);
      chk("hold_wlast", wlast, m_hold_last);
    end
    if (busy) busy_cnt++;
    if (burst_done) done_cyc.push_back(cyc);
    if (fifo_re) re_cyc.push_back(cyc);
    hs = !rst && wv && wready;
    last_hs = 1'b0;
    if (hs) begin
      hs_cyc.push_back(cyc);
      chk("beat_avail", ref_words.size() != 0, 1);
      if (ref_words.size() != 0) chk("wdata", wdata, ref_words.pop_front());
      last_hs = (m_beat == m_len);
      chk("wlast", wlast, last_hs);
    end
    acc = cmd_valid && !rst && !m_busy;
    if (acc) acc_cyc.push_back(cyc);
    pop = fifo_re;
    stall_next = !rst && wv && !wready;
    m_hold_data = wdata;
    m_hold_last = wlast;
    @(posedge clk);
    #1;
    if (pop && src.size() != 0) void'(src.pop_front());
    if (rst) begin
      // words already popped but not yet emitted are lost
      for (int i = 0; i < m_inflight; i++)
        if (ref_words.size() != 0) void'(ref_words.pop_front());
      m_busy = 0; m_done = 0; m_stall = 0;
      m_fetch = 0; m_beat = 0; m_inflight = 0;
    end else begin
      m_done  = hs && last_hs;
      m_stall = stall_next;
      if (er) begin m_fetch--; m_inflight++; end
      if (hs) begin m_inflight--; m_beat++; end
      if (m_done) begin m_busy = 0; m_beat = 0; end
      if (acc) begin
        m_busy = 1; m_fetch = int'(cmd_len) + 1; m_len = int'(cmd_len); m_beat = 0;
        cmds_pending--;
        if (cmds_pending <= 0) cmd_valid = 1'b0;
      end
    end
    if (push_owed > 0 && $urandom_range(0, 9) < 6) begin
      push(DW'($urandom));
      push_owed--;
    end
    if (wr_mode == 1) wready = ~wready;
    else if (wr_mode == 2) wready = ($urandom_range(0, 2) != 0);
    drive();
  endtask

  task automatic run_idle(int maxc);
    int n = 0;
    tick(); n++;
    while ((m_busy || cmds_pending > 0) && n < maxc) begin tick(); n++; end
    tick();  // cycle carrying burst_done
    chk("timeout_busy", m_busy, 0);
    chk("all_emitted", ref_words.size(), 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; wready = 1'b0;
    drive();
    @(posedge clk); #1;
    // reset state
    tick(); tick();
    chk("rst_wdata", wdata, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", burst_done, 0);
    rst = 1'b0;
    tick();

    // four words, wready high: back-to-back pops and beats
    clear_logs();
    for (int i = 0; i < 4; i++) push(DW'(16'hA000 + i));
    wready = 1'b1;
    send_cmd(3, 1);
    run_idle(20);
    chk("b4_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4 && re_cyc.size() == 4 && done_cyc.size() == 1) begin
      chk("b4_hs_consec", hs_cyc[3] - hs_cyc[0], 3);
      chk("b4_re_consec", re_cyc[3] - re_cyc[0], 3);
      chk("b4_done_cyc", done_cyc[0], hs_cyc[3] + 1);
    end

    // single-beat burst
    clear_logs();
    push(16'h5A5A);
    send_cmd(0, 1);
    run_idle(20);
    chk("len0_beats", hs_cyc.size(), 1);
    chk("len0_busy_cycles", busy_cnt, 2);

    // eight beats with wready toggling
    clear_logs();
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    wr_mode = 1;
    send_cmd(7, 1);
    run_idle(60);
    chk("tog_beats", hs_cyc.size(), 8);
    wr_mode = 0; wready = 1'b1;

    // FIFO runs dry after two words, refilled later
    clear_logs();
    push(16'h1111); push(16'h2222);
    send_cmd(3, 1);
    for (int i = 0; i < 7; i++) tick();
    push(16'h3333); push(16'h4444);
    run_idle(30);
    chk("dry_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) chk("dry_gap", (hs_cyc[2] - hs_cyc[1]) > 1, 1);

    // reset after two of four beats
    clear_logs();
    for (int i = 0; i < 4; i++) push(DW'(16'hC000 + i));
    send_cmd(3, 1);
    for (int i = 0; i < 20 && hs_cyc.size() < 2; i++) tick();
    chk("rst_mid_reached", hs_cyc.size(), 2);
    rst = 1'b1; wready = 1'b0;
    tick();
    chk("rst_mid_wvalid", wvalid, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 1'b0; wready = 1'b1;
    tick();
    chk("rst_mid_left", ref_words.size(), 1);
    clear_logs();
    push(16'hC0FF);
    send_cmd(1, 1);
    run_idle(20);
    chk("rst_next_beats", hs_cyc.size(), 2);

    // command held high across two bursts
    clear_logs();
    for (int i = 0; i < 4; i++) push(DW'(16'hB000 + i));
    send_cmd(1, 2);
    run_idle(40);
    chk("hold_beats", hs_cyc.size(), 4);
    chk("hold_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2 && hs_cyc.size() == 4)
      chk("hold_bubble", acc_cyc[1], hs_cyc[1] + 1);

    // random bursts, random FIFO fill and wready
    wr_mode = 2;
    for (int b = 0; b < 15; b++) begin
      int len;
      len = $urandom_range(0, 15);
      push_owed = len + 1;
      send_cmd(len, 1);
      run_idle(400);
    end
    wr_mode = 0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
